lsu_dmem_master: RTL
====================

Name: lsu_dmem_master

Overview:
Load/store unit that initiates all accesses to the data memory (dmem). It accepts byte, halfword and word load/store requests from the CPU pipeline over a valid/ready handshake. It converts each request into dmem word-port cycles: 22-bit word address, 32-bit dataIn, writeEnable, asynchronous dataOut. Sub-word stores use read-modify-write, because dmem has only a whole-word write enable.

Parameters:
ADDR_W, 22, dmem word-address width; dmem word address = req_addr[ADDR_W+1:2]
RESET_RDATA, 32'h0, value of resp_rdata after reset and after a store response

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous reset, active-low
req_valid  input  1  CPU request present
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address; bits above ADDR_W+1 ignored
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, extended; RESET_RDATA for stores
resp_fault  output  1  valid with resp_valid; reserved size or misalignment
mem_address  output  ADDR_W  dmem word address
mem_dataIn  output  32  dmem write data
mem_writeEnable  output  1  dmem word write strobe
mem_dataOut  input  32  dmem read data, combinational from mem_address

Behaviour:
- Reset (reset_n low at rising edge): state=IDLE, resp_valid=0, resp_fault=0, resp_rdata=RESET_RDATA, mem_address=0, mem_dataIn=0, mem_writeEnable=0. Reset mid-operation aborts with no response. A pending write strobe drops at that same edge.
- req_ready = (state==IDLE) && reset_n. Acceptance = req_valid && req_ready at a rising edge. At acceptance, latch write, size, signed, byte lane addr[1:0] and wdata. mem_address is also loaded and then held stable until the return to IDLE.
- States: IDLE, RD, RMW_RD, WR, RESP.
- Load: IDLE -> RD -> RESP -> IDLE.
  - In RD, sample mem_dataOut at the end of the cycle.
  - Lane select is little-endian: byte lane k = bits [8k+7:8k]; halfword at addr[1]*16.
  - Extend per req_signed.
  - resp_valid goes high exactly 2 cycles after acceptance.
- Word store: IDLE -> WR -> RESP -> IDLE.
  - mem_writeEnable=1 for exactly the WR cycle, with mem_dataIn=wdata.
- Sub-word store: IDLE -> RMW_RD -> WR -> RESP -> IDLE.
  - RMW_RD samples the old word.
  - WR writes the old word with only the addressed byte or halfword lane replaced.
  - Response at 3 cycles after acceptance.
- mem_writeEnable is 0 in every state except WR. mem_dataIn is held after WR until the next store.
- RESP: resp_valid=1 for one cycle only; no back-pressure. req_ready is 0 in RESP, so back-to-back requests see one idle gap. IDLE is re-entered on the next edge.
- Faults: size=11 gives IDLE -> RESP directly. No memory cycle occurs, resp_fault=1, resp_rdata=RESET_RDATA.
- Word accesses ignore nothing: address bits [1:0] are only used for lane selection.
- req_valid while not ready is ignored; requests are not queued.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 faults. The path is IDLE -> RESP with resp_fault=1, no dmem read or write, and mem_writeEnable never asserted.
- Undefined: the low bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0). The access proceeds normally with resp_fault=0.

Test Plan:
- Word store: addr 0x10, wdata 0xDEADBEEF -> mem_address=4, mem_writeEnable high for exactly 1 cycle, resp_valid 2 cycles after acceptance. A subsequent word load from 0x10 returns 0xDEADBEEF.
- Byte load, signed and unsigned: word 0x80FF7F01 at 0x20. Byte signed at 0x22 -> 0xFFFFFFFF. Byte unsigned at 0x23 -> 0x00000080. Half signed at 0x22 -> 0xFFFF80FF. Half unsigned at 0x20 -> 0x00007F01.
- RMW byte store: word 0x11223344 at 0x30. Store byte 0xAA at 0x31 -> one RMW_RD cycle, then a write of 0x1122AA44, response 3 cycles after acceptance.
- Reserved size: req_size=11 -> resp_fault=1 one cycle after acceptance, mem_writeEnable stays 0, memory unchanged.
- Reset mid-store: reset_n low during RMW_RD -> no write occurs, no resp_valid, all outputs return to reset values, req_ready=1 after release.
- Misaligned word load at 0x42:
  - With LSU_MISALIGN_TRAP_EN: resp_fault=1 and no dmem read.
  - Without it: the load reads word 0x40, with resp_fault=0.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - load/store unit driving the dmem word port, RMW for sub-word stores
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module lsu_dmem_master #(
  parameter int          ADDR_W      = 22,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_dataIn,
  output logic              mem_writeEnable,
  input  logic [31:0]       mem_dataOut
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [2:0]  state;
  logic [1:0]  latSize;
  logic        latSigned;
  logic [1:0]  latLane;
  logic [15:0] latWdata;

  logic        reqFault;
  logic [1:0]  reqLane;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadResult;
  logic [31:0] mergedWord;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^req_addr[31:ADDR_W+2];
  assign req_ready = (state == IDLE) && reset_n;

  // Lane is forced to natural alignment; with the trap enabled misaligned requests never reach memory.
  always_comb begin
    reqLane = req_addr[1:0];
    if (req_size == SIZE_HALF) begin
      reqLane[0] = 1'b0;
    end else if (req_size == SIZE_WORD) begin
      reqLane = 2'b00;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    reqFault = (req_size == 2'b11) ||
               ((req_size == SIZE_HALF) && req_addr[0]) ||
               ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    reqFault = (req_size == 2'b11);
`endif
  end

  always_comb begin
    case (latLane)
      2'd0:    laneByte = mem_dataOut[7:0];
      2'd1:    laneByte = mem_dataOut[15:8];
      2'd2:    laneByte = mem_dataOut[23:16];
      default: laneByte = mem_dataOut[31:24];
    endcase
    laneHalf = latLane[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];

    case (latSize)
      SIZE_BYTE: loadResult = {{24{latSigned & laneByte[7]}}, laneByte};
      SIZE_HALF: loadResult = {{16{latSigned & laneHalf[15]}}, laneHalf};
      default:   loadResult = mem_dataOut;
    endcase

    mergedWord = mem_dataOut;
    if (latSize == SIZE_BYTE) begin
      case (latLane)
        2'd0:    mergedWord[7:0]   = latWdata[7:0];
        2'd1:    mergedWord[15:8]  = latWdata[7:0];
        2'd2:    mergedWord[23:16] = latWdata[7:0];
        default: mergedWord[31:24] = latWdata[7:0];
      endcase
    end else if (latLane[1]) begin
      mergedWord[31:16] = latWdata;
    end else begin
      mergedWord[15:0] = latWdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      resp_valid      <= 1'b0;
      resp_fault      <= 1'b0;
      resp_rdata      <= RESET_RDATA;
      mem_address     <= '0;
      mem_dataIn      <= '0;
      mem_writeEnable <= 1'b0;
      latSize         <= SIZE_BYTE;
      latSigned       <= 1'b0;
      latLane         <= 2'b00;
      latWdata        <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            latSize     <= req_size;
            latSigned   <= req_signed;
            latLane     <= reqLane;
            latWdata    <= req_wdata[15:0];
            mem_address <= req_addr[ADDR_W+1:2];
            if (reqFault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= RESET_RDATA;
              state      <= RESP;
            end else if (req_write) begin
              if (req_size == SIZE_WORD) begin
                mem_dataIn      <= req_wdata;
                mem_writeEnable <= 1'b1;
                state           <= WR;
              end else begin
                state <= RMW_RD;
              end
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          resp_rdata <= loadResult;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_dataIn      <= mergedWord;
          mem_writeEnable <= 1'b1;
          state           <= WR;
        end
        WR: begin
          mem_writeEnable <= 1'b0;
          resp_rdata      <= RESET_RDATA;
          resp_valid      <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_writeEnable <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
